// File: rtl/mag_capture_ctrl_pkg.sv
// rtl/mag_capture_ctrl_pkg.sv - shared state encoding and capture word layout
package mag_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } cap_state_e;

  localparam int unsigned SMP_W  = 20;
  localparam int unsigned WD_W   = 6 * SMP_W;
  localparam int unsigned OFF_I  = 100;
  localparam int unsigned OFF_Q  = 80;
  localparam int unsigned OFF_M1 = 60;
  localparam int unsigned OFF_M2 = 40;
  localparam int unsigned OFF_M3 = 20;
  localparam int unsigned OFF_M4 = 0;

  function automatic logic [WD_W-1:0] pack_word(
    input logic [SMP_W-1:0] i_s,
    input logic [SMP_W-1:0] q_s,
    input logic [SMP_W-1:0] m1,
    input logic [SMP_W-1:0] m2,
    input logic [SMP_W-1:0] m3,
    input logic [SMP_W-1:0] m4
  );
    logic [WD_W-1:0] w;
    w = '0;
    w[OFF_I  +: SMP_W] = i_s;
    w[OFF_Q  +: SMP_W] = q_s;
    w[OFF_M1 +: SMP_W] = m1;
    w[OFF_M2 +: SMP_W] = m2;
    w[OFF_M3 +: SMP_W] = m3;
    w[OFF_M4 +: SMP_W] = m4;
    return w;
  endfunction

endpackage

// File: rtl/mag_capture_ctrl_iq_delay_line.sv
// rtl/mag_capture_ctrl_iq_delay_line.sv - resettable fixed-depth delay line
module iq_delay_line #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int k = 1; k < int'(DEPTH); k++) begin
          stage_d[k] = stage_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int k = 0; k < int'(DEPTH); k++) begin
          if (!reset_b) begin
            stage_q[k] <= '0;
          end else begin
            stage_q[k] <= stage_d[k];
          end
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mag_capture_ctrl.sv
// rtl/mag_capture_ctrl.sv - triggered capture of aligned IQ plus basis magnitudes
module mag_capture_ctrl
  import mag_capture_ctrl_pkg::*;
#(
  parameter int unsigned MAG_LAT = 4,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [SMP_W-1:0]  sig_in_i,
  input  logic [SMP_W-1:0]  sig_in_q,
  input  logic [SMP_W-1:0]  mag_1,
  input  logic [SMP_W-1:0]  mag_2,
  input  logic [SMP_W-1:0]  mag_3,
  input  logic [SMP_W-1:0]  mag_4,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   cap_len,
  input  logic [15:0]       trig_dly,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WD_W-1:0]   wr_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   wr_count
);

  logic [2*SMP_W-1:0] iq_aligned;

  iq_delay_line #(
    .DEPTH(MAG_LAT),
    .WIDTH(2*SMP_W)
  ) u_iq_dly (
    .clk    (clk),
    .reset_b(reset_b),
    .din    ({sig_in_i, sig_in_q}),
    .dout   (iq_aligned)
  );

  cap_state_e        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [15:0]       dly_q, dly_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WD_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    dly_d      = dly_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    done_d     = 1'b0;
    aborted_d  = aborted_q;
    case (state_q)
      ST_IDLE: begin
        // abort outranks a coincident start
        if (start && !abort) begin
          len_d      = cap_len;
          dly_d      = trig_dly;
          wr_count_d = '0;
          wr_addr_d  = '0;
          aborted_d  = 1'b0;
          state_d    = (trig_dly == 16'd0) ? ST_CAPT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (dly_q == 16'd1) begin
          state_d = ST_CAPT;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end
      ST_CAPT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (wr_count_q == len_q) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          wr_addr_d = '0;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = wr_count_q[ADDR_W-1:0];
          wr_data_d  = pack_word(iq_aligned[2*SMP_W-1:SMP_W], iq_aligned[SMP_W-1:0],
                                 mag_1, mag_2, mag_3, mag_4);
          wr_count_d = wr_count_q + (ADDR_W+1)'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_WAIT) || (state_d == ST_CAPT);
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      dly_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      dly_q      <= dly_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule
